// File: rtl/alu_wb_buffer.sv
// Two-entry skid buffer carrying ALU results (result, rd, we) from execute to register-file writeback.
// Optional feature: define ALU_WB_ZERO_FLAG_EN to store a per-entry result==0 flag that drives out_zero.
module alu_wb_buffer #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_result,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_we,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_we,
  output logic                  out_zero
);

  // State bits are {skid_valid, main_valid}; 2'b10 is illegal.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
`ifdef ALU_WB_ZERO_FLAG_EN
    logic                  zero;
`endif
  } entry_t;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   in_fire;
  logic   out_fire;

  assign in_ready  = ~state_q[1];
  assign out_valid = state_q[0];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    in_entry.result = in_result;
    in_entry.rd     = in_rd;
    in_entry.we     = in_we;
`ifdef ALU_WB_ZERO_FLAG_EN
    in_entry.zero   = (in_result == '0);
`endif
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          case ({in_fire, out_fire})
            2'b10: begin
              skid_d  = in_entry;
              state_d = TWO;
            end
            2'b01:   state_d = EMPTY;
            2'b11:   main_d  = in_entry;
            default: state_d = ONE;
          endcase
        end
        TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: data registers are reset too, because out_result/out_rd must read 0 straight out of reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_result = main_q.result;
  assign out_rd     = main_q.rd;
  // Writes to x0 are suppressed but the entry is still delivered.
  assign out_we     = main_q.we & (main_q.rd != '0);
`ifdef ALU_WB_ZERO_FLAG_EN
  assign out_zero   = main_q.zero;
`else
  assign out_zero   = 1'b0;
`endif

  a_no_skid_without_main: assert property (
    @(posedge clk) disable iff (!rst_n) !(state_q[1] && !state_q[0])
  );

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Randomized and directed bench for alu_wb_buffer; a FIFO-of-two reference model feeds a scoreboard.
module tb_alu_wb_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_rd;
  logic        in_we;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_zero;

  alu_wb_buffer #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_rd      (in_rd),
    .in_we      (in_we),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_we     (out_we),
    .out_zero   (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  rd;
    logic        we;
    logic        z;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   pops  = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] r, input logic [4:0] rd, input logic we);
    exp_t e;
    e.r  = r;
    e.rd = rd;
    e.we = we && (rd != 5'd0);
`ifdef ALU_WB_ZERO_FLAG_EN
    e.z  = (r == 32'd0);
`else
    e.z  = 1'b0;
`endif
    return e;
  endfunction

  // Scoreboard monitor: the model is a FIFO of capacity two; flush empties it.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      bit acc_in, acc_out;
      acc_in  = in_valid && (exp_q.size() < 2);
      acc_out = out_ready && (exp_q.size() != 0);
      check("in_ready", in_ready, exp_q.size() < 2);
      check("out_valid", out_valid, exp_q.size() != 0);
      if (out_valid && exp_q.size() != 0) begin
        check("out_result", out_result, exp_q[0].r);
        check("out_rd", out_rd, exp_q[0].rd);
        check("out_we", out_we, exp_q[0].we);
        check("out_zero", out_zero, exp_q[0].z);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (acc_out) begin
          void'(exp_q.pop_front());
          pops++;
        end
        if (acc_in) exp_q.push_back(model(in_result, in_rd, in_we));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one result and hold it until accepted, with a bounded wait.
  task automatic send(input logic [31:0] d, input logic [4:0] rd, input logic we);
    bit acc;
    in_valid  = 1'b1;
    in_result = d;
    in_rd     = rd;
    in_we     = we;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_result"}, out_result, 0);
    check({tag, "_out_rd"}, out_rd, 0);
    check({tag, "_out_we"}, out_we, 0);
    check({tag, "_out_zero"}, out_zero, 0);
  endtask

  initial begin
    int c0, p0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    in_rd     = '0;
    in_we     = 1'b0;
    out_ready = 1'b1;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single result, then latency check one cycle after acceptance.
    send(32'hF0F0_0F0F, 5'd3, 1'b1);
    check("single_valid", out_valid, 1);
    check("single_result", out_result, 32'hF0F0_0F0F);
    check("single_in_ready", in_ready, 1);
    repeat (2) tick();

    // Back-pressure: third offer must wait until the head drains.
    out_ready = 1'b0;
    send(32'h1, 5'd1, 1'b1);
    send(32'h2, 5'd2, 1'b1);
    in_valid  = 1'b1;
    in_result = 32'h3;
    repeat (3) tick();
    check("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    send(32'h3, 5'd3, 1'b1);
    repeat (4) tick();

    // Streaming: 100 back-to-back results, one per cycle.
    c0 = cyc;
    p0 = pops;
    for (int i = 0; i < 100; i++) send(32'h100 + i, 5'(i % 32), 1'b1);
    check("stream_cycles", cyc - c0, 100);
    tick();
    check("stream_pops", pops - p0, 100);
    repeat (2) tick();

    // x0 suppression and zero-flag cases.
    send(32'hDEAD_BEEF, 5'd0, 1'b1);
    check("x0_valid", out_valid, 1);
    check("x0_we", out_we, 0);
    send(32'h0, 5'd4, 1'b1);
`ifdef ALU_WB_ZERO_FLAG_EN
    check("zero_flag_set", out_zero, 1);
`else
    check("zero_flag_off", out_zero, 0);
`endif
    send(32'h8000_0000, 5'd5, 1'b1);
    check("zero_flag_clear", out_zero, 0);
    repeat (2) tick();

    // Flush in TWO with an input offered at the same edge.
    out_ready = 1'b0;
    send(32'hAAAA_0001, 5'd6, 1'b1);
    send(32'hAAAA_0002, 5'd7, 1'b1);
    in_valid  = 1'b1;
    in_result = 32'hBAD0_0001;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    // Flush in ONE while an input transfer is accepted.
    send(32'hAAAA_0003, 5'd8, 1'b1);
    in_valid  = 1'b1;
    in_result = 32'hBAD0_0002;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    check("flush1_out_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (4) tick();

    // Asynchronous reset mid-stream, asserted away from any clock edge.
    out_ready = 1'b0;
    send(32'h5555_0001, 5'd9, 1'b1);
    send(32'h5555_0002, 5'd10, 1'b1);
    in_valid  = 1'b1;
    in_result = 32'h5555_0003;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_result = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      in_rd     = 5'($urandom_range(0, 31));
      in_we     = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    check("drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_wb_buffer.md
# alu_wb_buffer

Two-entry skid buffer between the execute stage, where the 32-bit ALU operation units such as the bitwise OR unit produce results, and register-file writeback. It registers each ALU result with its destination register and write enable. It decouples execute from writeback stalls with a valid/ready handshake and never drops or duplicates a result. A synchronous flush discards in-flight results on a pipeline redirect.

## Interface
Parameters:
- DATA_W, 32, ALU result width
- REG_ADDR_W, 5, destination register index width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous discard of all buffered entries
- in_valid  input  1  execute presents a result
- in_ready  output  1  buffer can accept; registered, equals NOT skid_valid
- in_result  input  DATA_W  ALU result (e.g. a | b)
- in_rd  input  REG_ADDR_W  destination register
- in_we  input  1  result must be written
- out_valid  output  1  head entry valid
- out_ready  input  1  writeback accepts head entry
- out_result  output  DATA_W  head result
- out_rd  output  REG_ADDR_W  head destination
- out_we  output  1  head write enable, forced 0 when head rd == 0
- out_zero  output  1  head result == 0 (see Configuration)

## Operation
- Storage: main register (head, drives out_*) and skid register; each has a valid bit.
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY: input transfer goes to main → ONE.
  - ONE: input only goes to skid → TWO. Output only → EMPTY. Both at once: new entry loads main, stays ONE.
  - TWO: in_ready = 0. Output transfer moves skid into main → ONE. No output → hold.
- Input is never accepted in TWO. State {skid_valid=1, main_valid=0} is illegal and unreachable; assertion target.
- Ordering is strict FIFO.
- out_we = stored we AND (stored rd != 0). Register x0 is never written, but the entry is still delivered.
- flush: at the edge, main_valid and skid_valid clear and any simultaneous input transfer is discarded. Next state is EMPTY. Flush overrides every other event. in_ready returns to 1 the cycle after flush.
- Data registers load only on the transfer that targets them. They hold their value otherwise, including while invalid.

## Timing
- Latency: a result accepted at edge N is on out_* with out_valid = 1 after edge N, i.e. in cycle N+1.
- Throughput: 1 result/cycle when out_ready is held 1.
- in_ready depends only on registered state; there is no combinational path from out_ready to in_ready.
- out_* depend only on registers.
- Reset (rst_n low, asynchronous): main_valid = skid_valid = 0, in_ready = 1, out_valid = 0, out_result = 0, out_rd = 0, out_we = 0, out_zero = 0.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Downstream may drop out_ready at any time; out_* stay stable while out_valid && !out_ready.

## Configuration
- ALU_WB_ZERO_FLAG_EN defined: a zero flag is computed as in_result == 0 when the entry is captured. It is stored per entry and travels with it; out_zero reflects the head entry.
- Not defined: no flag storage; out_zero is tied to 0.

## Test plan
- Reset then single result: in_result = 0xF0F0_0F0F, rd = 3, we = 1, out_ready = 1. Required: out_valid in the next cycle with 0xF0F0_0F0F, rd 3, out_we 1, and in_ready stays 1.
- Back-pressure: out_ready = 0, send 0x1, 0x2, then offer 0x3. Required: in_ready = 0 after the second accept and 0x3 is not taken. Release out_ready; required order on output is 0x1, 0x2, 0x3.
- Streaming: 100 consecutive results with out_ready = 1 and incrementing data. Required: one output per cycle, in order, no gaps after the first.
- x0 suppression: rd = 0, we = 1, result 0xDEAD_BEEF. Required: delivered with out_valid = 1 and out_we = 0.
- Flush with simultaneous input in TWO. Required: EMPTY next cycle, out_valid = 0, in_ready = 1, and no flushed data ever appears. Async reset asserted mid-stream: all outputs 0 immediately.
- With ALU_WB_ZERO_FLAG_EN: result 0x0 gives out_zero = 1; result 0x8000_0000 gives out_zero = 0. Without the macro, out_zero = 0 for both.
